// File: rtl/t_sync_counter.sv
// Modulo up/down counter built from T flip-flop equations: every update is
// q ^ t, with t derived from the carry/borrow toggle chains or the load value.
module t_sync_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             wrap_flag
);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] t_inc;
    logic [WIDTH-1:0] t_dec;
    logic [WIDTH-1:0] load_sat;
    logic             wrap_evt;

    // Bit i toggles when all lower bits are 1 (increment) or all 0 (decrement).
    always_comb begin
        t_inc = '0;
        t_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] low;
            low      = (WIDTH'(1) << i) - WIDTH'(1);
            t_inc[i] = ((q & low) == low);
            t_dec[i] = ((~q & low) == low);
        end
    end

    always_comb begin
        t        = '0;
        wrap_evt = 1'b0;
        load_sat = (load_val > mod_val) ? mod_val : load_val;
        if (load) begin
            t = q ^ load_sat;
        end else if (en) begin
            if (up) begin
                if (q >= mod_val) begin
                    t        = q;
                    wrap_evt = 1'b1;
                end else begin
                    t = t_inc;
                end
            end else begin
                // q above mod_val only happens if mod_val dropped mid-count.
                if (q == '0 || q > mod_val) begin
                    t        = q ^ mod_val;
                    wrap_evt = 1'b1;
                end else begin
                    t = t_dec;
                end
            end
        end
    end

    assign tc = wrap_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            t_vec     <= '0;
            wrap_flag <= 1'b0;
        end else begin
            q     <= q ^ t;
            t_vec <= t;
            if (wrap_evt)
                wrap_flag <= 1'b1;
            else if (clr_wrap)
                wrap_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_t_sync_counter.sv
// Directed vector bench for t_sync_counter (WIDTH=4).
module tb_t_sync_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load, clr_wrap;
    logic [3:0] load_val, mod_val;
    logic [3:0] q, t_vec;
    logic       tc, wrap_flag;

    int n_tests = 0;
    int n_fail  = 0;

    t_sync_counter #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .mod_val(mod_val), .clr_wrap(clr_wrap),
        .q(q), .t_vec(t_vec), .tc(tc), .wrap_flag(wrap_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, up, ld;
        logic [3:0] lv, mv;
        logic       clr;
        logic       etc;
        logic [3:0] eq, et;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_i, logic en_i, logic up_i, logic ld_i,
                                logic [3:0] lv_i, logic [3:0] mv_i, logic clr_i,
                                logic etc_i, logic [3:0] eq_i, logic [3:0] et_i,
                                logic ew_i);
        vec_t v;
        v.rst = rst_i; v.en = en_i; v.up = up_i; v.ld = ld_i;
        v.lv = lv_i; v.mv = mv_i; v.clr = clr_i;
        v.etc = etc_i; v.eq = eq_i; v.et = et_i; v.ew = ew_i;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // rst en up ld lv mv clr | tc  q  t  wrap
        vecs.push_back(mk(1,0,0,0, 0, 9,0, 0, 0,4'b0000,0));
        // count up mod 9 for 12 cycles
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 1,4'b0001,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 2,4'b0011,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 3,4'b0001,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 4,4'b0111,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 5,4'b0001,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 6,4'b0011,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 7,4'b0001,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 8,4'b1111,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 9,4'b0001,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 1, 0,4'b1001,1));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 1,4'b0001,1));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 0, 2,4'b0011,1));
        vecs.push_back(mk(0,0,1,0, 0, 9,1, 0, 2,4'b0000,0));
        // down wrap from 0, then decrement
        vecs.push_back(mk(1,0,0,0, 0, 9,0, 0, 0,4'b0000,0));
        vecs.push_back(mk(0,1,0,0, 0, 9,0, 1, 9,4'b1001,1));
        vecs.push_back(mk(0,1,0,0, 0, 9,0, 0, 8,4'b0001,1));
        vecs.push_back(mk(0,1,0,0, 0, 9,0, 0, 7,4'b1111,1));
        // mod_val lowered below q, wrap with clr_wrap on same edge
        vecs.push_back(mk(0,1,1,0, 0, 4,1, 1, 0,4'b0111,1));
        vecs.push_back(mk(0,0,1,0, 0, 4,1, 0, 0,4'b0000,0));
        // saturated load beats en, tc low in load cycle
        vecs.push_back(mk(0,1,1,1,13, 9,0, 0, 9,4'b1001,0));
        vecs.push_back(mk(0,0,1,1, 6, 9,0, 0, 6,4'b1111,0));
        vecs.push_back(mk(0,1,1,1, 9, 9,0, 0, 9,4'b1111,0));
        vecs.push_back(mk(0,1,1,0, 0, 9,0, 1, 0,4'b1001,1));
        vecs.push_back(mk(0,0,1,1, 6, 9,0, 0, 6,4'b0110,1));
        // reset beats load and en
        vecs.push_back(mk(1,1,1,1, 3, 9,0, 0, 0,4'b0000,0));
        vecs.push_back(mk(0,0,1,1, 5, 9,0, 0, 5,4'b0101,0));
        vecs.push_back(mk(0,0,1,0, 0, 9,0, 0, 5,4'b0000,0));
        vecs.push_back(mk(0,0,0,0, 0, 9,0, 0, 5,4'b0000,0));
        vecs.push_back(mk(0,0,1,0, 0, 9,0, 0, 5,4'b0000,0));
        // mod_val == 0 with up toggling
        vecs.push_back(mk(0,1,1,0, 0, 0,0, 1, 0,4'b0101,1));
        vecs.push_back(mk(0,1,0,0, 0, 0,0, 1, 0,4'b0000,1));
        vecs.push_back(mk(0,1,1,0, 0, 0,0, 1, 0,4'b0000,1));
        vecs.push_back(mk(0,1,0,0, 0, 0,0, 1, 0,4'b0000,1));

        reset = 1; en = 0; up = 0; load = 0; clr_wrap = 0;
        load_val = 0; mod_val = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
            load = vecs[i].ld; load_val = vecs[i].lv; mod_val = vecs[i].mv;
            clr_wrap = vecs[i].clr;
            #1;
            if (!vecs[i].rst) check($sformatf("v%0d_tc", i), tc, vecs[i].etc);
            @(posedge clk); #1;
            check($sformatf("v%0d_q", i), q, vecs[i].eq);
            check($sformatf("v%0d_t", i), t_vec, vecs[i].et);
            check($sformatf("v%0d_wrap", i), wrap_flag, vecs[i].ew);
        end

        // reset mid-count acts only on the edge
        @(negedge clk);
        reset = 1; en = 0; load = 0; clr_wrap = 0; mod_val = 9; up = 1;
        @(negedge clk);
        reset = 0; en = 1;
        repeat (3) @(negedge clk);
        check("count3", q, 3);
        reset = 1;
        #1 check("rst_no_async", q, 3);
        @(posedge clk); #1 check("rst_sync", q, 0);
        @(negedge clk);
        reset = 0; load = 1; load_val = 4;
        @(posedge clk); #1 check("post_rst_load", q, 4);
        @(negedge clk);
        load_val = 15; mod_val = 15;
        @(posedge clk); #1 check("load_max", q, 15);
        @(negedge clk);
        load = 0;
        #1 check("tc_max", tc, 1);
        @(posedge clk); #1;
        check("max_wrap_q", q, 0);
        check("max_wrap_t", t_vec, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
